// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin transaction arbiter sharing the SPIMux input side between two SPI engines,
// with an inter-owner select gap and a watchdog that revokes overlong grants.
module spi_arbiter #(
    parameter int                     GAP_CYCLES     = 2,
    parameter int                     TIMEOUT_W      = 16,
    parameter logic [TIMEOUT_W-1:0]   TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       SClk,
    input  logic       nReset,
    input  logic [1:0] Req,
    output logic [1:0] Gnt,
    input  logic [1:0] InSPISel,
    input  logic [1:0] InSPIDo,
    input  logic [1:0] InSPIClkRunning,
    output logic       OutSPISel,
    output logic       OutSPIDo,
    output logic       OutSPIClkRunning,
    output logic [1:0] Timeout,
    output logic       Busy
);
    localparam int                   GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]        GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] WD_LAST  = TIMEOUT_CYCLES - TIMEOUT_W'(1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t               state, state_nx;
    logic                 owner, owner_nx, last_owner, last_owner_nx;
    logic [1:0]           lockout, lockout_nx, timeout_nx;
    logic [TIMEOUT_W-1:0] wd, wd_nx;
    logic [GW-1:0]        gap_cnt, gap_nx;
    logic [1:0]           elig;
    logic                 pick, expire, granted;

    assign elig    = Req & ~lockout;
    // on a tie the requester that did not own the bus last wins
    assign pick    = (elig == 2'b11) ? ~last_owner : elig[1];
    assign expire  = (TIMEOUT_CYCLES != '0) && (wd == WD_LAST);
    assign granted = (state == GRANT);

    assign Gnt              = granted ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign OutSPISel        = granted & InSPISel[owner];
    assign OutSPIDo         = granted & InSPIDo[owner];
    assign OutSPIClkRunning = granted & InSPIClkRunning[owner];
    assign Busy             = (state != IDLE);

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_owner_nx = last_owner;
        lockout_nx    = lockout & Req;
        timeout_nx    = 2'b00;
        wd_nx         = wd;
        gap_nx        = gap_cnt;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_nx = GRANT;
                    owner_nx = pick;
                    wd_nx    = '0;
                end
            end
            GRANT: begin
                wd_nx = (wd == '1) ? wd : wd + TIMEOUT_W'(1);
                // a release in the expiry cycle wins over the watchdog
                if (!Req[owner]) begin
                    state_nx      = GAP;
                    last_owner_nx = owner;
                    gap_nx        = '0;
                end else if (expire) begin
                    state_nx          = GAP;
                    timeout_nx[owner] = 1'b1;
                    lockout_nx[owner] = 1'b1;
                    gap_nx            = '0;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nx = IDLE;
                else gap_nx = gap_cnt + GW'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge SClk) begin
        if (!nReset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lockout    <= 2'b00;
            Timeout    <= 2'b00;
            wd         <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
            lockout    <= lockout_nx;
            Timeout    <= timeout_nx;
            wd         <= wd_nx;
            gap_cnt    <= gap_nx;
        end
    end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: scenario tests for spi_arbiter; expected output vectors are queued with each
// stimulus cycle and checked one cycle later against {Gnt, Sel, Do, ClkRunning, Timeout, Busy}.
module tb_spi_arbiter;
    logic       SClk = 1'b0;
    logic       nReset;
    logic [1:0] Req, InSPISel, InSPIDo, InSPIClkRunning;
    logic [1:0] Gnt, Timeout, w_Gnt, w_Timeout;
    logic       OutSPISel, OutSPIDo, OutSPIClkRunning, Busy;
    logic       w_OutSPISel, w_OutSPIDo, w_OutSPIClkRunning, w_Busy;
    logic [7:0] mon, mon_w, e;
    logic [7:0] exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 SClk = ~SClk;

    spi_arbiter dut (
        .SClk(SClk), .nReset(nReset), .Req(Req), .Gnt(Gnt),
        .InSPISel(InSPISel), .InSPIDo(InSPIDo), .InSPIClkRunning(InSPIClkRunning),
        .OutSPISel(OutSPISel), .OutSPIDo(OutSPIDo), .OutSPIClkRunning(OutSPIClkRunning),
        .Timeout(Timeout), .Busy(Busy)
    );

    // short watchdog instance for the timeout scenarios
    spi_arbiter #(.TIMEOUT_CYCLES(16'd10)) dut_wd (
        .SClk(SClk), .nReset(nReset), .Req(Req), .Gnt(w_Gnt),
        .InSPISel(InSPISel), .InSPIDo(InSPIDo), .InSPIClkRunning(InSPIClkRunning),
        .OutSPISel(w_OutSPISel), .OutSPIDo(w_OutSPIDo), .OutSPIClkRunning(w_OutSPIClkRunning),
        .Timeout(w_Timeout), .Busy(w_Busy)
    );

    assign mon   = {Gnt, OutSPISel, OutSPIDo, OutSPIClkRunning, Timeout, Busy};
    assign mon_w = {w_Gnt, w_OutSPISel, w_OutSPIDo, w_OutSPIClkRunning, w_Timeout, w_Busy};

    function automatic logic [7:0] ev(input logic [1:0] g, input logic s, d, c,
                                      input logic [1:0] t, input logic b);
        return {g, s, d, c, t, b};
    endfunction

    task automatic tick();
        @(posedge SClk);
        #1;
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        Req = 2'b00; InSPISel = 2'b00; InSPIDo = 2'b00; InSPIClkRunning = 2'b00;
        tick();
        tick();
        nReset = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] ew;
        for (int c = 0; c < 3; c++) begin
            nReset = (c == 2);
            Req = (c == 2) ? 2'b00 : 2'b11;
            InSPISel = 2'b11; InSPIDo = 2'b11; InSPIClkRunning = 2'b11;
            exp_q.push_back(8'h00);
            tick();
            ew = exp_q.pop_front();
            n_chk++;
            if ({mon, mon_w} !== {ew, ew}) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b/%b expected %b", c, mon, mon_w, ew);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 23; c++) begin
            Req = (c < 20) ? 2'b01 : 2'b00;
            InSPISel = 2'b01;
            InSPIDo = {1'b1, c[0]};
            InSPIClkRunning = {1'b1, c[1]};
            exp_q.push_back((c < 20) ? ev(2'b01, 1'b1, c[0], c[1], 2'b00, 1'b1)
                                     : ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, c < 22));
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (mon !== e) begin
                n_fail++;
                $display("FAIL single[%0d]: got %b expected %b", c, mon, e);
            end
        end
    endtask

    task automatic test_fairness();
        logic o;
        do_reset();
        InSPISel = 2'b11; InSPIDo = 2'b10; InSPIClkRunning = 2'b01;
        for (int r = 0; r < 4; r++) begin
            o = r[0];
            for (int k = 0; k < 11; k++) begin
                Req = (k == 8) ? (o ? 2'b01 : 2'b10) : 2'b11;
                exp_q.push_back((k < 8) ? ev(o ? 2'b10 : 2'b01, 1'b1, o, ~o, 2'b00, 1'b1)
                                        : ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, k < 10));
                tick();
                e = exp_q.pop_front();
                n_chk++;
                if (mon !== e) begin
                    n_fail++;
                    $display("FAIL fairness[r%0d k%0d]: got %b expected %b", r, k, mon, e);
                end
            end
        end
    endtask

    task automatic test_isolation();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            Req = 2'b11;
            InSPISel = {1'($urandom), 1'b1};
            InSPIDo = {1'($urandom), c[0]};
            InSPIClkRunning = {1'($urandom), c[1]};
            exp_q.push_back(ev(2'b01, 1'b1, c[0], c[1], 2'b00, 1'b1));
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (mon !== e) begin
                n_fail++;
                $display("FAIL isolation[%0d]: got %b expected %b", c, mon, e);
            end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        InSPISel = 2'b10; InSPIDo = 2'b00; InSPIClkRunning = 2'b00;
        for (int c = 0; c < 20; c++) begin
            Req = (c == 17) ? 2'b00 : 2'b10;
            exp_q.push_back((c < 10 || c > 17) ? ev(2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1) :
                            (c == 10)          ? ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1) :
                                                 ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, c == 11));
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (mon_w !== e) begin
                n_fail++;
                $display("FAIL watchdog[%0d]: got %b expected %b", c, mon_w, e);
            end
        end
    endtask

    task automatic test_collision();
        do_reset();
        InSPISel = 2'b01; InSPIDo = 2'b00; InSPIClkRunning = 2'b00;
        for (int c = 0; c < 15; c++) begin
            Req = (c == 10) ? 2'b00 : 2'b01;
            exp_q.push_back((c < 10 || c > 12) ? ev(2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1)
                                               : ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, c < 12));
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (mon_w !== e) begin
                n_fail++;
                $display("FAIL collision[%0d]: got %b expected %b", c, mon_w, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        InSPISel = 2'b11; InSPIDo = 2'b00; InSPIClkRunning = 2'b00;
        for (int c = 0; c < 11; c++) begin
            nReset = (c != 8);
            Req = (c < 3) ? 2'b01 : (c < 6) ? 2'b00 : (c < 8) ? 2'b10 : 2'b11;
            exp_q.push_back((c < 3 || c > 8)  ? ev(2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1) :
                            (c == 6 || c == 7) ? ev(2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1) :
                                                 ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, c == 3 || c == 4));
            tick();
            e = exp_q.pop_front();
            n_chk++;
            if (mon !== e) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got %b expected %b", c, mon, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_isolation();
        test_watchdog();
        test_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
